// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding slice of the RV32I pipeline.
//   OP_*       : RV32I major opcodes used by decode to classify producers
//   reg_idx_t  : architectural register index
//   fwd_src_t  : which pipeline stage a bypass value is taken from
package hazard_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_MEM,
      FWD_WB
   } fwd_src_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle of the hazard scoreboard unit.
//   slave  : the hazard unit (consumes pipeline state, drives stall/bypass)
//   master : the pipeline (drives issue/EX/MEM/WB state, consumes stall/bypass)
// Issue-stage  : iss_valid_i, iss_rs1_i, iss_rs2_i, iss_use_rs1_i, iss_use_rs2_i
// EX-stage     : ex_valid_i, ex_is_load_i, ex_rd_i, ex_rs1_i, ex_rs2_i
// MEM producers: mem_valid_i, mem_is_load_i, mem_rd_i, mem_data_i
// WB producers : wb_valid_i, wb_rd_i, wb_data_i
// Control      : flush_i
// Results      : stall_o, fwd_rs1_en_o, fwd_rs2_en_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
interface hazard_scoreboard_unit_if import hazard_pkg::*; #(
   parameter int unsigned ISSUE_W = 2,
   parameter int unsigned XLEN    = 32
);

   logic     [ISSUE_W-1:0]           iss_valid_i;
   reg_idx_t [ISSUE_W-1:0]           iss_rs1_i;
   reg_idx_t [ISSUE_W-1:0]           iss_rs2_i;
   logic     [ISSUE_W-1:0]           iss_use_rs1_i;
   logic     [ISSUE_W-1:0]           iss_use_rs2_i;

   logic     [ISSUE_W-1:0]           ex_valid_i;
   logic     [ISSUE_W-1:0]           ex_is_load_i;
   reg_idx_t [ISSUE_W-1:0]           ex_rd_i;
   reg_idx_t [ISSUE_W-1:0]           ex_rs1_i;
   reg_idx_t [ISSUE_W-1:0]           ex_rs2_i;

   logic     [ISSUE_W-1:0]           mem_valid_i;
   logic     [ISSUE_W-1:0]           mem_is_load_i;
   reg_idx_t [ISSUE_W-1:0]           mem_rd_i;
   logic     [ISSUE_W-1:0][XLEN-1:0] mem_data_i;

   logic     [ISSUE_W-1:0]           wb_valid_i;
   reg_idx_t [ISSUE_W-1:0]           wb_rd_i;
   logic     [ISSUE_W-1:0][XLEN-1:0] wb_data_i;

   logic                             flush_i;

   logic                             stall_o;
   logic     [ISSUE_W-1:0]           fwd_rs1_en_o;
   logic     [ISSUE_W-1:0]           fwd_rs2_en_o;
   logic     [ISSUE_W-1:0][XLEN-1:0] fwd_rs1_o;
   logic     [ISSUE_W-1:0][XLEN-1:0] fwd_rs2_o;
   logic     [31:0]                  stall_cnt_o;

   modport slave (
      input  iss_valid_i, iss_rs1_i, iss_rs2_i, iss_use_rs1_i, iss_use_rs2_i,
      input  ex_valid_i, ex_is_load_i, ex_rd_i, ex_rs1_i, ex_rs2_i,
      input  mem_valid_i, mem_is_load_i, mem_rd_i, mem_data_i,
      input  wb_valid_i, wb_rd_i, wb_data_i,
      input  flush_i,
      output stall_o, fwd_rs1_en_o, fwd_rs2_en_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
   );

   modport master (
      output iss_valid_i, iss_rs1_i, iss_rs2_i, iss_use_rs1_i, iss_use_rs2_i,
      output ex_valid_i, ex_is_load_i, ex_rd_i, ex_rs1_i, ex_rs2_i,
      output mem_valid_i, mem_is_load_i, mem_rd_i, mem_data_i,
      output wb_valid_i, wb_rd_i, wb_data_i,
      output flush_i,
      input  stall_o, fwd_rs1_en_o, fwd_rs2_en_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
   );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Bypass source selection for one EX consumer operand.
//   rs_i                        : consumer register index
//   mem_valid_i/mem_is_load_i   : MEM producers (loads are not yet forwardable)
//   mem_rd_i/mem_data_i         : MEM producer destination and result
//   wb_valid_i/wb_rd_i/wb_data_i: WB producers
//   en_o/data_o                 : bypass enable and value (0 when no producer)
// Any MEM producer beats any WB producer; within a stage the youngest
// (highest slot index) wins. x0 is never forwarded.
module fwd_select import hazard_pkg::*; #(
   parameter int unsigned N    = 2,
   parameter int unsigned XLEN = 32
) (
   input  reg_idx_t               rs_i,
   input  logic     [N-1:0]       mem_valid_i,
   input  logic     [N-1:0]       mem_is_load_i,
   input  reg_idx_t [N-1:0]       mem_rd_i,
   input  logic     [N-1:0][XLEN-1:0] mem_data_i,
   input  logic     [N-1:0]       wb_valid_i,
   input  reg_idx_t [N-1:0]       wb_rd_i,
   input  logic     [N-1:0][XLEN-1:0] wb_data_i,
   output logic                   en_o,
   output logic     [XLEN-1:0]    data_o
);

   fwd_src_t src;

   // Later assignments override earlier ones: WB scanned first, then MEM,
   // each in ascending slot order, so the last match is the winner.
   always_comb begin
      src    = FWD_NONE;
      data_o = '0;
      for (int unsigned s = 0; s < N; s++) begin
         if (wb_valid_i[s] && (wb_rd_i[s] == rs_i)) begin
            src    = FWD_WB;
            data_o = wb_data_i[s];
         end
      end
      for (int unsigned s = 0; s < N; s++) begin
         if (mem_valid_i[s] && !mem_is_load_i[s] && (mem_rd_i[s] == rs_i)) begin
            src    = FWD_MEM;
            data_o = mem_data_i[s];
         end
      end
      if (rs_i == '0) begin
         src    = FWD_NONE;
         data_o = '0;
      end
   end

   assign en_o = (src != FWD_NONE);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding and load-use hazard unit for the ISSUE_W-wide in-order pipeline.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   hz     : pipeline bundle (slave side), see hazard_scoreboard_unit_if
// A per-register countdown scoreboard remembers loads that have left EX but
// whose data is not yet forwardable from WB; a load currently in EX is seen
// directly. Issue stalls while any read operand matches either. Bypass
// selection for each EX operand is delegated to fwd_select.
module hazard_scoreboard_unit import hazard_pkg::*; #(
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned XLEN     = 32
) (
   input logic                     clk_i,
   input logic                     rstn_i,
   hazard_scoreboard_unit_if.slave hz
);

   localparam int unsigned   CW       = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);

   logic [CW-1:0]      cnt_q [1:31];
   logic [31:1]        load_set;
   logic [31:0]        pending;
   logic [ISSUE_W-1:0] hit;
   logic               stall;
   logic [31:0]        stall_cnt_q;

   // pending[r]: r is being produced by a load not yet forwardable.
   // Bit 0 is never set, which keeps x0 reads hazard-free.
   always_comb begin
      load_set = '0;
      pending  = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         pending[r] = (cnt_q[r] != '0);
         for (int unsigned s = 0; s < ISSUE_W; s++) begin
            if (hz.ex_valid_i[s] && hz.ex_is_load_i[s] && (hz.ex_rd_i[s] == reg_idx_t'(r))) begin
               pending[r] = 1'b1;
               if (!hz.flush_i) load_set[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned r = 1; r < 32; r++) cnt_q[r] <= '0;
      end else begin
         for (int unsigned r = 1; r < 32; r++) begin
            if (load_set[r])            cnt_q[r] <= CNT_INIT;
            else if (cnt_q[r] != '0)    cnt_q[r] <= cnt_q[r] - 1'b1;
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int unsigned s = 0; s < ISSUE_W; s++) begin
         hit[s] = hz.iss_valid_i[s] &
                  ((hz.iss_use_rs1_i[s] & pending[hz.iss_rs1_i[s]]) |
                   (hz.iss_use_rs2_i[s] & pending[hz.iss_rs2_i[s]]));
      end
   end

   assign stall    = (|hit) & ~hz.flush_i;
   assign hz.stall_o = stall;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)                          stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign hz.stall_cnt_o = stall_cnt_q;

   for (genvar s = 0; s < ISSUE_W; s++) begin : g_fwd
      logic            rs1_en;
      logic            rs2_en;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;

      fwd_select #(.N(ISSUE_W), .XLEN(XLEN)) u_rs1 (
         .rs_i          (hz.ex_rs1_i[s]),
         .mem_valid_i   (hz.mem_valid_i),
         .mem_is_load_i (hz.mem_is_load_i),
         .mem_rd_i      (hz.mem_rd_i),
         .mem_data_i    (hz.mem_data_i),
         .wb_valid_i    (hz.wb_valid_i),
         .wb_rd_i       (hz.wb_rd_i),
         .wb_data_i     (hz.wb_data_i),
         .en_o          (rs1_en),
         .data_o        (rs1_data)
      );

      fwd_select #(.N(ISSUE_W), .XLEN(XLEN)) u_rs2 (
         .rs_i          (hz.ex_rs2_i[s]),
         .mem_valid_i   (hz.mem_valid_i),
         .mem_is_load_i (hz.mem_is_load_i),
         .mem_rd_i      (hz.mem_rd_i),
         .mem_data_i    (hz.mem_data_i),
         .wb_valid_i    (hz.wb_valid_i),
         .wb_rd_i       (hz.wb_rd_i),
         .wb_data_i     (hz.wb_data_i),
         .en_o          (rs2_en),
         .data_o        (rs2_data)
      );

      assign hz.fwd_rs1_en_o[s] = rs1_en;
      assign hz.fwd_rs2_en_o[s] = rs2_en;
      assign hz.fwd_rs1_o[s]    = rs1_data;
      assign hz.fwd_rs2_o[s]    = rs2_data;
   end

endmodule
